// File: rtl/mem_stage_ctrl_if.sv
// Execute-stage op handshake, d-cache request/response and writeback bus of the
// memory stage. master = execute stage / d-cache side, slave = mem_stage_ctrl.
interface mem_stage_ctrl_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  logic                      i_valid;
  logic                      o_ready;
  logic                      i_is_mem_access;
  logic                      i_mem_write;
  logic [1:0]                i_size;
  logic                      i_sign_ext;
  logic [DATA_WIDTH-1:0]     i_alu_result;
  logic [DATA_WIDTH-1:0]     i_sw_data;
  logic                      i_uses_rw;
  logic [REG_ADDR_WIDTH-1:0] i_rw_addr;
  logic                      o_cache_req;
  logic                      o_cache_write;
  logic [DATA_WIDTH-1:0]     o_cache_addr;
  logic [DATA_WIDTH-1:0]     o_cache_data;
  logic                      i_cache_valid;
  logic [DATA_WIDTH-1:0]     i_cache_data;
  logic                      o_wb_valid;
  logic                      o_wb_uses_rw;
  logic [REG_ADDR_WIDTH-1:0] o_wb_rw_addr;
  logic [DATA_WIDTH-1:0]     o_wb_rw_data;
  logic                      o_misalign;
  logic                      o_timeout;

  modport master (
    output i_valid, i_is_mem_access, i_mem_write, i_size, i_sign_ext,
           i_alu_result, i_sw_data, i_uses_rw, i_rw_addr, i_cache_valid, i_cache_data,
    input  o_ready, o_cache_req, o_cache_write, o_cache_addr, o_cache_data,
           o_wb_valid, o_wb_uses_rw, o_wb_rw_addr, o_wb_rw_data, o_misalign, o_timeout
  );

  modport slave (
    input  i_valid, i_is_mem_access, i_mem_write, i_size, i_sign_ext,
           i_alu_result, i_sw_data, i_uses_rw, i_rw_addr, i_cache_valid, i_cache_data,
    output o_ready, o_cache_req, o_cache_write, o_cache_addr, o_cache_data,
           o_wb_valid, o_wb_uses_rw, o_wb_rw_addr, o_wb_rw_data, o_misalign, o_timeout
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory stage controller: captures an op, issues one d-cache request per aligned
// load/store, aligns load data and emits a single-cycle writeback (or misalign/timeout).
module mem_stage_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int TIMEOUT        = 255
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_ctrl_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam int         CW   = $clog2(TIMEOUT);

  logic [0:0]                state;
  logic [CW-1:0]             cnt;
  logic                      write_q, sext_q, uses_q;
  logic [1:0]                size_q;
  logic [DATA_WIDTH-1:0]     addr_q, sw_data_q;
  logic [REG_ADDR_WIDTH-1:0] rw_q;
  logic                      wb_valid, wb_uses, misalign, timeout;
  logic [DATA_WIDTH-1:0]     wb_data;

  logic                      accept, misal_in;
  logic [31:0]               lo_word;
  logic [7:0]                byte_v;
  logic [15:0]               half_v;
  logic [DATA_WIDTH-1:0]     load_data;

  assign accept = bus.i_valid && (state == IDLE);
  // size 11 falls into the word case through size[1]
  assign misal_in = (bus.i_size == 2'b01 && bus.i_alu_result[0]) ||
                    (bus.i_size[1] && (bus.i_alu_result[1:0] != 2'b00));

  // Little-endian lane select from the low 32 bits of the returned word
  always_comb begin
    lo_word   = bus.i_cache_data[31:0];
    byte_v    = 8'(lo_word >> {addr_q[1:0], 3'b000});
    half_v    = addr_q[1] ? lo_word[31:16] : lo_word[15:0];
    load_data = bus.i_cache_data;
    case (size_q)
      2'b00:   load_data = {{(DATA_WIDTH-8){sext_q & byte_v[7]}}, byte_v};
      2'b01:   load_data = {{(DATA_WIDTH-16){sext_q & half_v[15]}}, half_v};
      default: load_data = bus.i_cache_data;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      sext_q    <= 1'b0;
      uses_q    <= 1'b0;
      size_q    <= 2'b00;
      addr_q    <= '0;
      sw_data_q <= '0;
      rw_q      <= '0;
      wb_valid  <= 1'b0;
      wb_uses   <= 1'b0;
      misalign  <= 1'b0;
      timeout   <= 1'b0;
      wb_data   <= '0;
    end else begin
      wb_valid <= 1'b0;
      wb_uses  <= 1'b0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q   <= bus.i_mem_write;
            sext_q    <= bus.i_sign_ext;
            uses_q    <= bus.i_uses_rw;
            size_q    <= bus.i_size;
            addr_q    <= bus.i_alu_result;
            sw_data_q <= bus.i_sw_data;
            rw_q      <= bus.i_rw_addr;
            if (!bus.i_is_mem_access) begin
              wb_valid <= 1'b1;
              wb_uses  <= bus.i_uses_rw && (bus.i_rw_addr != '0);
              wb_data  <= bus.i_alu_result;
            end else if (misal_in) begin
              wb_valid <= 1'b1;
              misalign <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= '0;
            end
          end
        end
        default: begin
          // completion beats a coincident terminal timeout count
          if (bus.i_cache_valid) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_uses  <= !write_q && uses_q && (rw_q != '0);
            wb_data  <= write_q ? '0 : load_data;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            state    <= IDLE;
            cnt      <= '0;
            wb_valid <= 1'b1;
            timeout  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.o_ready       = (state == IDLE);
  assign bus.o_cache_req   = (state == WAIT);
  assign bus.o_cache_write = write_q;
  assign bus.o_cache_addr  = {addr_q[DATA_WIDTH-1:2], 2'b00};
  assign bus.o_cache_data  = sw_data_q;
  assign bus.o_wb_valid    = wb_valid;
  assign bus.o_wb_uses_rw  = wb_uses;
  assign bus.o_wb_rw_addr  = rw_q;
  assign bus.o_wb_rw_data  = wb_data;
  assign bus.o_misalign    = misalign;
  assign bus.o_timeout     = timeout;
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed + randomized bench for mem_stage_ctrl (TIMEOUT=4) against a
// transaction-level model of the memory stage.
module tb_mem_stage_ctrl;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_stage_ctrl_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  mem_stage_ctrl #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    assert (act === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference: little-endian byte/half pick with arithmetic extension
  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                           input logic [1:0] sz, input bit sx);
    longint unsigned v;
    if (sz == 2'd0) begin
      v = (longint'(w) >> (8 * a[1:0])) % 256;
      if (sx && v >= 128) v = v + 64'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (longint'(w) >> (16 * a[1])) % 65536;
      if (sx && v >= 32768) v = v + 64'hFFFF_0000;
    end else begin
      v = longint'(w);
    end
    return v[31:0];
  endfunction

  task automatic do_op(input bit mem, input bit wr, input logic [1:0] size, input bit sext,
                       input logic [31:0] addr, input logic [31:0] sw, input bit uses,
                       input logic [4:0] rw, input int lat, input logic [31:0] cdata);
    bit misal, to, exp_uses;
    int n;
    misal    = mem && ((size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0));
    to       = mem && !misal && (lat < 1 || lat > TO);
    n        = (lat < 1 || lat > TO) ? TO : lat;
    exp_uses = uses && (rw != 0) && !(mem && (wr || misal || to));

    bus.i_valid = 1'b1; bus.i_is_mem_access = mem; bus.i_mem_write = wr;
    bus.i_size = size; bus.i_sign_ext = sext; bus.i_alu_result = addr;
    bus.i_sw_data = sw; bus.i_uses_rw = uses; bus.i_rw_addr = rw;
    step;
    // scramble op fields so the DUT must rely on what it captured
    bus.i_valid = 1'b0; bus.i_alu_result = $urandom; bus.i_sw_data = $urandom;
    bus.i_rw_addr = 5'($urandom); bus.i_mem_write = 1'($urandom); bus.i_size = 2'($urandom);
    bus.i_sign_ext = 1'($urandom); bus.i_uses_rw = 1'($urandom);

    if (!mem || misal) begin
      chk("imm_wb_valid", bus.o_wb_valid, 1);
      chk("imm_misalign", bus.o_misalign, misal);
      chk("imm_uses_rw", bus.o_wb_uses_rw, exp_uses);
      chk("imm_cache_req", bus.o_cache_req, 0);
      chk("imm_ready", bus.o_ready, 1);
      if (!mem) begin
        chk("alu_rw_addr", bus.o_wb_rw_addr, rw);
        chk("alu_data", bus.o_wb_rw_data, addr);
      end
    end else begin
      for (int k = 1; k <= n; k++) begin
        chk("wait_cache_req", bus.o_cache_req, 1);
        chk("wait_ready", bus.o_ready, 0);
        chk("wait_wb_valid", bus.o_wb_valid, 0);
        chk("wait_cache_addr", bus.o_cache_addr, {addr[31:2], 2'b00});
        chk("wait_cache_write", bus.o_cache_write, wr);
        if (wr) chk("wait_cache_data", bus.o_cache_data, sw);
        bus.i_cache_valid = (k == lat);
        bus.i_cache_data  = (k == lat) ? cdata : $urandom;
        step;
      end
      bus.i_cache_valid = 1'b0;
      chk("done_wb_valid", bus.o_wb_valid, 1);
      chk("done_timeout", bus.o_timeout, to);
      chk("done_misalign", bus.o_misalign, 0);
      chk("done_uses_rw", bus.o_wb_uses_rw, exp_uses);
      chk("done_cache_req", bus.o_cache_req, 0);
      chk("done_ready", bus.o_ready, 1);
      if (!to) chk("done_rw_addr", bus.o_wb_rw_addr, rw);
      if (!wr && !to) chk("load_data", bus.o_wb_rw_data, load_val(cdata, addr, size, sext));
    end

    // idle cycle: pulses must drop and a stray cache_valid must be ignored
    bus.i_cache_valid = 1'($urandom);
    bus.i_cache_data  = $urandom;
    step;
    bus.i_cache_valid = 1'b0;
    chk("pulse_wb_valid", bus.o_wb_valid, 0);
    chk("pulse_misalign", bus.o_misalign, 0);
    chk("pulse_timeout", bus.o_timeout, 0);
    chk("idle_cache_req", bus.o_cache_req, 0);
  endtask

  initial begin
    bit mem, wr, sext, uses;
    logic [1:0] size;
    logic [31:0] addr;

    rst = 1'b1;
    bus.i_valid = 0; bus.i_is_mem_access = 0; bus.i_mem_write = 0; bus.i_size = 0;
    bus.i_sign_ext = 0; bus.i_alu_result = 0; bus.i_sw_data = 0; bus.i_uses_rw = 0;
    bus.i_rw_addr = 0; bus.i_cache_valid = 0; bus.i_cache_data = 0;
    step; step;
    chk("rst_wb_valid", bus.o_wb_valid, 0);
    chk("rst_cache_req", bus.o_cache_req, 0);
    chk("rst_misalign", bus.o_misalign, 0);
    chk("rst_timeout", bus.o_timeout, 0);
    chk("rst_cache_addr", bus.o_cache_addr, 0);
    chk("rst_wb_data", bus.o_wb_rw_data, 0);
    rst = 1'b0;
    step;
    chk("post_rst_ready", bus.o_ready, 1);

    // ALU op, byte loads signed/unsigned, misaligned word, timeout and its near miss
    do_op(0, 0, 2'd2, 0, 32'h1234, 0, 1, 5'd3, 0, 0);
    do_op(1, 0, 2'd0, 1, 32'h1003, 0, 1, 5'd7, 3, 32'h80FF_0000);
    do_op(1, 0, 2'd0, 0, 32'h1003, 0, 1, 5'd7, 3, 32'h80FF_0000);
    do_op(1, 0, 2'd2, 0, 32'h1002, 0, 1, 5'd4, 1, 32'hDEAD_BEEF);
    do_op(1, 0, 2'd2, 0, 32'h2000, 0, 1, 5'd5, 0, 0);
    do_op(1, 0, 2'd2, 0, 32'h2000, 0, 1, 5'd5, TO, 32'hCAFE_F00D);
    // store with $0 and load to $0; signed half in upper lane; size 11 as word
    do_op(1, 1, 2'd2, 0, 32'h3000, 32'h5555_AAAA, 1, 5'd0, 2, 0);
    do_op(1, 0, 2'd2, 0, 32'h3004, 0, 1, 5'd0, 1, 32'h1111_2222);
    do_op(1, 0, 2'd1, 1, 32'h4002, 0, 1, 5'd9, 2, 32'h8001_7FFF);
    do_op(1, 0, 2'd3, 0, 32'h4001, 0, 1, 5'd9, 1, 32'h0);
    do_op(1, 0, 2'd3, 0, 32'h4008, 0, 1, 5'd9, 1, 32'h9876_5432);

    // back-to-back ALU ops: one accepted per cycle while each writeback pulses
    bus.i_valid = 1; bus.i_is_mem_access = 0; bus.i_uses_rw = 1;
    for (int i = 0; i < 4; i++) begin
      bus.i_alu_result = 32'(100 + i);
      bus.i_rw_addr = 5'(i + 1);
      step;
      chk("b2b_wb_valid", bus.o_wb_valid, 1);
      chk("b2b_data", bus.o_wb_rw_data, 100 + i);
      chk("b2b_rw_addr", bus.o_wb_rw_addr, i + 1);
      chk("b2b_ready", bus.o_ready, 1);
    end
    bus.i_valid = 0;
    step;
    chk("b2b_end", bus.o_wb_valid, 0);

    // reset in WAIT drops the request without a writeback
    bus.i_valid = 1; bus.i_is_mem_access = 1; bus.i_mem_write = 0; bus.i_size = 2'd2;
    bus.i_alu_result = 32'h5000; bus.i_rw_addr = 5'd6;
    step;
    bus.i_valid = 0;
    chk("rw_cache_req", bus.o_cache_req, 1);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rw_cache_req_rst", bus.o_cache_req, 0);
    chk("rw_ready", bus.o_ready, 1);
    chk("rw_wb_valid", bus.o_wb_valid, 0);
    chk("rw_cache_addr", bus.o_cache_addr, 0);
    bus.i_cache_valid = 1;
    step;
    bus.i_cache_valid = 0;
    chk("rw_no_wb", bus.o_wb_valid, 0);
    chk("rw_no_req", bus.o_cache_req, 0);

    for (int r = 0; r < 40; r++) begin
      mem  = ($urandom % 4) != 0;
      wr   = 1'($urandom);
      size = 2'($urandom);
      sext = 1'($urandom);
      uses = 1'($urandom);
      addr = $urandom;
      if (($urandom % 4) != 0) addr = (size == 2'd0) ? addr : (size == 2'd1) ? {addr[31:1], 1'b0}
                                                                             : {addr[31:2], 2'b00};
      do_op(mem, wr, size, sext, addr, $urandom, uses, 5'($urandom), $urandom_range(0, 6), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
